// File: rtl/axi_rd_burst_split.sv
// AXI4 read-channel burst splitter: long INCR bursts are issued as MAX_BURST_LEN sub-bursts,
// and the R stream is re-joined by masking rlast on every sub-burst except the final one.
module axi_rd_burst_split #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int MAX_BURST_LEN  = 16,
  parameter int CMD_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic [3:0]            s_axi_arregion,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic [3:0]            m_axi_arregion,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;
  localparam int         PTR_W = $clog2(CMD_FIFO_DEPTH);
  localparam logic [8:0] MAX_BEATS  = 9'(MAX_BURST_LEN);
  localparam logic [7:0] MAX_LEN_M1 = 8'(MAX_BURST_LEN - 1);
  localparam logic [1:0] BURST_INCR = 2'b01;

  logic [0:0]            state_reg;
  logic [8:0]            remaining_reg;
  logic [ADDR_WIDTH-1:0] next_addr_reg;
  logic                  m_arvalid_reg;
  logic [ID_WIDTH-1:0]   m_arid_reg;
  logic [ADDR_WIDTH-1:0] m_araddr_reg;
  logic [7:0]            m_arlen_reg;
  logic [2:0]            m_arsize_reg;
  logic [1:0]            m_arburst_reg;
  logic                  m_arlock_reg;
  logic [3:0]            m_arcache_reg;
  logic [2:0]            m_arprot_reg;
  logic [3:0]            m_arqos_reg;
  logic [3:0]            m_arregion_reg;

  logic                  fifo_mem [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W:0]        count_reg;

  logic                  fifo_full, fifo_empty, push, pop, push_last;
  logic                  s_hs, s_split, slot_free, split_load;
  logic [8:0]            s_beats, sub_beats, rem_after;
  logic [ADDR_WIDTH-1:0] s_step, split_step;

  assign fifo_full  = (count_reg == (PTR_W+1)'(CMD_FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign slot_free  = (!m_arvalid_reg || m_axi_arready) && !fifo_full;

  assign s_axi_arready = (state_reg == IDLE) && !m_arvalid_reg && !fifo_full;
  assign s_hs          = s_axi_arvalid && s_axi_arready;
  assign s_beats       = {1'b0, s_axi_arlen} + 9'd1;
  assign s_split       = (s_axi_arburst == BURST_INCR) && (s_beats > MAX_BEATS);
  assign s_step        = ADDR_WIDTH'(MAX_BURST_LEN) << s_axi_arsize;

  // The m-side size register still holds the original size while splitting.
  assign split_load = (state_reg == SPLIT) && slot_free;
  assign sub_beats  = (remaining_reg > MAX_BEATS) ? MAX_BEATS : remaining_reg;
  assign rem_after  = remaining_reg - sub_beats;
  assign split_step = ADDR_WIDTH'(MAX_BURST_LEN) << m_arsize_reg;

  assign push      = s_hs || split_load;
  assign push_last = s_hs ? !s_split : (rem_after == 9'd0);
  assign pop       = m_axi_rvalid && m_axi_rready && m_axi_rlast && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      remaining_reg  <= '0;
      next_addr_reg  <= '0;
      m_arvalid_reg  <= 1'b0;
      m_arid_reg     <= '0;
      m_araddr_reg   <= '0;
      m_arlen_reg    <= '0;
      m_arsize_reg   <= '0;
      m_arburst_reg  <= '0;
      m_arlock_reg   <= 1'b0;
      m_arcache_reg  <= '0;
      m_arprot_reg   <= '0;
      m_arqos_reg    <= '0;
      m_arregion_reg <= '0;
    end else if (s_hs) begin
      m_arvalid_reg  <= 1'b1;
      m_arid_reg     <= s_axi_arid;
      m_araddr_reg   <= s_axi_araddr;
      m_arsize_reg   <= s_axi_arsize;
      m_arburst_reg  <= s_axi_arburst;
      m_arlock_reg   <= s_axi_arlock;
      m_arcache_reg  <= s_axi_arcache;
      m_arprot_reg   <= s_axi_arprot;
      m_arqos_reg    <= s_axi_arqos;
      m_arregion_reg <= s_axi_arregion;
      if (s_split) begin
        m_arlen_reg   <= MAX_LEN_M1;
        remaining_reg <= s_beats - MAX_BEATS;
        next_addr_reg <= s_axi_araddr + s_step;
        state_reg     <= SPLIT;
      end else begin
        m_arlen_reg   <= s_axi_arlen;
      end
    end else if (split_load) begin
      m_arvalid_reg <= 1'b1;
      m_araddr_reg  <= next_addr_reg;
      m_arlen_reg   <= 8'(sub_beats - 9'd1);
      remaining_reg <= rem_after;
      next_addr_reg <= next_addr_reg + split_step;
      if (rem_after == 9'd0) begin
        state_reg <= IDLE;
      end
    end else if (m_axi_arready) begin
      m_arvalid_reg <= 1'b0;
    end
  end

  // Command FIFO: one "is final sub-burst" bit per outstanding master-side burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + (PTR_W+1)'(1);
      else if (pop && !push) count_reg <= count_reg - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_last;
  end

  assign m_axi_arvalid  = m_arvalid_reg;
  assign m_axi_arid     = m_arid_reg;
  assign m_axi_araddr   = m_araddr_reg;
  assign m_axi_arlen    = m_arlen_reg;
  assign m_axi_arsize   = m_arsize_reg;
  assign m_axi_arburst  = m_arburst_reg;
  assign m_axi_arlock   = m_arlock_reg;
  assign m_axi_arcache  = m_arcache_reg;
  assign m_axi_arprot   = m_arprot_reg;
  assign m_axi_arqos    = m_arqos_reg;
  assign m_axi_arregion = m_arregion_reg;

  // With an empty FIFO the master misbehaved; pass rlast through rather than hide it.
  assign s_axi_rvalid = m_axi_rvalid;
  assign m_axi_rready = s_axi_rready;
  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast && (fifo_empty || fifo_mem[rd_ptr_reg]);
endmodule

// File: tb/tb_axi_rd_burst_split.sv
// Bench for axi_rd_burst_split: directed plan steps plus random commands, checked against
// an arithmetic model of the expected sub-burst list and of where s-side rlast must fall.
module tb_axi_rd_burst_split;
  localparam int MBL = 16;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
  } ar_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ar_t         s_cmd, m_ar_now, stall_ar, exp_e;
  logic        s_axi_arvalid, s_axi_arready;
  logic [7:0]  s_axi_rid, m_axi_rid;
  logic [31:0] s_axi_rdata, m_axi_rdata;
  logic [1:0]  s_axi_rresp, m_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [7:0]  m_axi_arid, m_axi_arlen;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [3:0]  m_axi_arcache, m_axi_arqos, m_axi_arregion;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_rd_burst_split dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_arid(s_cmd.id), .s_axi_araddr(s_cmd.addr), .s_axi_arlen(s_cmd.len),
    .s_axi_arsize(s_cmd.size), .s_axi_arburst(s_cmd.burst), .s_axi_arlock(s_cmd.lock),
    .s_axi_arcache(s_cmd.cache), .s_axi_arprot(s_cmd.prot), .s_axi_arqos(s_cmd.qos),
    .s_axi_arregion(s_cmd.region), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  assign m_ar_now = {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                     m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion};

  int   total = 0, bad = 0, cyc = 0;
  ar_t  exp_ar_q[$], pend_q[$];
  int   exp_burst_q[$], ar_cyc_q[$];
  int   s_beat_idx = 0, cur_beat = 0, m_ar_count = 0, last_s_cyc = 0;
  int   r_rate = 100, rr_rate = 100, ar_rate = 100, ar_limit = 1 << 30;
  logic r_hold = 1'b0, beat_taken = 1'b0, stall_prev = 1'b0, exp_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected master-side commands: INCR longer than MBL beats becomes ceil(beats/MBL) chunks.
  function automatic void model_push(input ar_t c);
    int beats = int'(c.len) + 1;
    ar_t e;
    if (c.burst == INCR && beats > MBL) begin
      for (int k = 0; k * MBL < beats; k++) begin
        e = c;
        e.addr = c.addr + 32'(k * MBL * (1 << c.size));
        e.len  = 8'(((beats - k * MBL) < MBL ? (beats - k * MBL) : MBL) - 1);
        exp_ar_q.push_back(e);
      end
    end else begin
      exp_ar_q.push_back(c);
    end
    exp_burst_q.push_back(beats);
  endfunction

  function automatic ar_t mk(input logic [31:0] a, input int len, input int sz, input logic [1:0] b);
    ar_t c;
    c.id = 8'($urandom); c.addr = a; c.len = 8'(len); c.size = 3'(sz); c.burst = b;
    c.lock = 1'($urandom); c.cache = 4'($urandom); c.prot = 3'($urandom);
    c.qos = 4'($urandom); c.region = 4'($urandom);
    return c;
  endfunction

  function automatic ar_t rand_cmd();
    int kind = $urandom_range(0, 3);
    int sz = $urandom_range(0, 2);
    int len, bytes;
    logic [31:0] a = $urandom;
    logic [31:0] amask = ~32'((1 << sz) - 1);
    if (kind == 0) return mk(a & amask, $urandom_range(0, 15), sz, FIXED);
    if (kind == 1) return mk(a & amask, (2 << $urandom_range(0, 3)) - 1, sz, WRAP);
    len   = $urandom_range(0, 255);
    bytes = (len + 1) << sz;
    a     = {a[31:12], 12'($urandom_range(0, 4096 - bytes))} & amask;
    return mk(a, len, sz, INCR);
  endfunction

  // Downstream slave: answers DUT ARs in order with random data/resp and random throttling.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (beat_taken) begin
        if (m_axi_rlast) begin
          void'(pend_q.pop_front());
          cur_beat = 0;
        end else begin
          cur_beat++;
        end
      end
      if (!m_axi_rvalid || beat_taken) begin
        if (pend_q.size() != 0 && !r_hold && $urandom_range(0, 99) < r_rate) begin
          m_axi_rvalid = 1'b1;
          m_axi_rid    = pend_q[0].id;
          m_axi_rdata  = $urandom;
          m_axi_rresp  = 2'($urandom_range(0, 3));
          m_axi_rlast  = (cur_beat == int'(pend_q[0].len));
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
        end
      end
      beat_taken    = 1'b0;
      m_axi_arready = (m_ar_count < ar_limit) && ($urandom_range(0, 99) < ar_rate);
      s_axi_rready  = $urandom_range(0, 99) < rr_rate;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("ar_hold_valid", 128'(m_axi_arvalid), 128'(1));
        check("ar_hold_fields", 128'(m_ar_now), 128'(stall_ar));
      end
      stall_prev = m_axi_arvalid && !m_axi_arready;
      stall_ar   = m_ar_now;
      if (m_axi_arvalid && m_axi_arready) begin
        m_ar_count++;
        ar_cyc_q.push_back(cyc);
        check("ar_pending", 128'(exp_ar_q.size() != 0), 128'(1));
        if (exp_ar_q.size() != 0) begin
          exp_e = exp_ar_q.pop_front();
          check("m_ar", 128'(m_ar_now), 128'(exp_e));
        end
        pend_q.push_back(m_ar_now);
      end
      check("rvalid_pass", 128'(s_axi_rvalid), 128'(m_axi_rvalid));
      if (m_axi_rvalid) check("rready_pass", 128'(m_axi_rready), 128'(s_axi_rready));
      beat_taken = m_axi_rvalid && m_axi_rready;
      if (m_axi_rvalid && s_axi_rready) begin
        s_beat_idx++;
        check("r_expected", 128'(exp_burst_q.size() != 0), 128'(1));
        exp_last = (exp_burst_q.size() != 0) && (s_beat_idx == exp_burst_q[0]);
        check("r_beat", 128'({s_axi_rid, s_axi_rdata, s_axi_rresp}),
              128'({m_axi_rid, m_axi_rdata, m_axi_rresp}));
        check("s_rlast", 128'(s_axi_rlast), 128'(exp_last));
        if (exp_last) begin
          void'(exp_burst_q.pop_front());
          s_beat_idx = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_ar(input ar_t c);
    int n;
    s_cmd = c;
    s_axi_arvalid = 1'b1;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (s_axi_arready) break;
    end
    check("ar_accept", 128'(n < 3000), 128'(1));
    if (n < 3000) begin
      model_push(c);
      last_s_cyc = cyc;
    end
    step();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_ar_q.size() != 0 || exp_burst_q.size() != 0) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 128'(n < 8000), 128'(1));
    step();
  endtask

  initial begin
    int base;
    s_cmd = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1; m_axi_arready = 1'b1;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arvalid", 128'(m_axi_arvalid), 128'(0));
    check("rst_ar_fields", 128'(m_ar_now), 128'(0));
    check("rst_rvalid", 128'(s_axi_rvalid), 128'(0));
    check("rst_rlast", 128'(s_axi_rlast), 128'(0));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_arready", 128'(s_axi_arready), 128'(1));
    step();

    base = m_ar_count;
    send_ar(mk(32'h100, 3, 2, INCR));
    drain("short");
    check("short_count", 128'(m_ar_count - base), 128'(1));

    base = m_ar_count;
    r_hold = 1'b1;
    send_ar(mk(32'h1000, 39, 2, INCR));
    repeat (5) step();
    check("long_count", 128'(m_ar_count - base), 128'(3));
    check("long_latency", 128'(ar_cyc_q[base]), 128'(last_s_cyc + 1));
    check("long_back2back", 128'(ar_cyc_q[base + 2]), 128'(last_s_cyc + 3));
    r_hold = 1'b0;
    drain("long");

    base = m_ar_count;
    send_ar(mk(32'h1C0, 15, 2, INCR));
    send_ar(mk(32'h2000, 16, 2, INCR));
    send_ar(mk(32'h2400, 31, 2, FIXED));
    send_ar(mk(32'h3C, 15, 2, WRAP));
    drain("boundary_pass");
    check("boundary_pass_count", 128'(m_ar_count - base), 128'(5));

    base = m_ar_count;
    ar_limit = base + 1;
    send_ar(mk(32'h7000, 47, 2, INCR));
    for (int i = 0; i < 50 && m_ar_count != base + 1; i++) step();
    repeat (5) step();
    check("bp_stalled_valid", 128'(m_axi_arvalid), 128'(1));
    ar_limit = 1 << 30;
    drain("backpressure");
    check("bp_count", 128'(m_ar_count - base), 128'(3));

    base = m_ar_count;
    r_hold = 1'b1;
    send_ar(mk(32'h4000, 255, 2, INCR));
    repeat (20) step();
    check("full_count", 128'(m_ar_count - base), 128'(4));
    check("full_arvalid", 128'(m_axi_arvalid), 128'(0));
    r_hold = 1'b0;
    drain("full");
    check("full_total", 128'(m_ar_count - base), 128'(16));

    r_rate = 60; rr_rate = 70; ar_rate = 60;
    for (int i = 0; i < 25; i++) send_ar(rand_cmd());
    drain("random");
    r_rate = 100; rr_rate = 100; ar_rate = 100;

    base = m_ar_count;
    ar_limit = base + 2;
    r_hold = 1'b1;
    send_ar(mk(32'h5000, 39, 2, INCR));
    repeat (4) step();
    check("rst_pre_count", 128'(m_ar_count - base), 128'(2));
    check("rst_pre_valid", 128'(m_axi_arvalid), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_drop", 128'(m_axi_arvalid), 128'(0));
    exp_ar_q.delete(); exp_burst_q.delete(); pend_q.delete();
    s_beat_idx = 0; cur_beat = 0; beat_taken = 1'b0; stall_prev = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    r_hold = 1'b0; ar_limit = 1 << 30;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_post_arready", 128'(s_axi_arready), 128'(1));
    step();
    base = m_ar_count;
    send_ar(mk(32'h6000, 0, 2, INCR));
    drain("post_reset");
    check("post_reset_count", 128'(m_ar_count - base), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
